// File: rtl/id_ex_stage.sv
// id_ex_stage
// Decode-to-execute pipeline register. Captures the decoded control bundle,
// operands and register indices from ID and presents them to EX under a
// valid/ready handshake. Inserts a bubble on a load-use hazard, kills the
// EX entry on flush, and keeps saturating stall/flush event counters.
//
// Ports:
//   clock, reset          clock; asynchronous active-high reset
//   id_valid / id_ready   ID-side handshake
//   id_pc .. id_imm       XLEN-wide payload from ID
//   id_rs1/rs2/rd         register indices; id_uses_rs1/2 qualify the reads
//   id_reg_write .. id_alu_ctrl  decoded control bundle
//   flush                 taken branch / redirect
//   ex_ready / ex_valid   EX-side handshake
//   ex_*                  registered payload, indices and control
//   load_use_stall        combinational hazard indicator
//   stall_count, flush_count  saturating performance counters
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic [3:0]       ex_alu_ctrl,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d, rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic             rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
    logic             m2r_q, m2r_d, br_q, br_d;
    logic [3:0]       alu_q, alu_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             hazard, ready, accept;

    // A load in EX whose destination is read by the instruction in ID.
    // x0 is never a real dependency.
    assign hazard = valid_q & mr_q & (rd_q != 5'd0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == rd_q)) |
                     (id_uses_rs2 & (id_rs2 == rd_q)));

    assign ready  = ~flush & ~hazard & (~valid_q | ex_ready);
    assign accept = id_valid & ready;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        mr_d       = mr_q;
        mw_d       = mw_q;
        m2r_d      = m2r_q;
        br_d       = br_q;
        alu_d      = alu_q;
        if (flush || (!accept && valid_q && ex_ready)) begin
            // Flush and bubble both kill the entry; data fields are kept,
            // only control is zeroed so the dead slot has no side effects.
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            m2r_d   = 1'b0;
            br_d    = 1'b0;
            alu_d   = '0;
        end else if (accept) begin
            valid_d    = 1'b1;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            rw_d       = id_reg_write;
            mr_d       = id_mem_read;
            mw_d       = id_mem_write;
            m2r_d      = id_mem_to_reg;
            br_d       = id_branch;
            alu_d      = id_alu_ctrl;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush  && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            m2r_q       <= 1'b0;
            br_q        <= 1'b0;
            alu_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            mr_q        <= mr_d;
            mw_q        <= mw_d;
            m2r_q       <= m2r_d;
            br_q        <= br_d;
            alu_q       <= alu_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign id_ready       = ready;
    assign load_use_stall = hazard;
    assign ex_valid       = valid_q;
    assign ex_pc          = pc_q;
    assign ex_rs1_data    = rs1_data_q;
    assign ex_rs2_data    = rs2_data_q;
    assign ex_imm         = imm_q;
    assign ex_rs1         = rs1_q;
    assign ex_rs2         = rs2_q;
    assign ex_rd          = rd_q;
    assign ex_reg_write   = rw_q;
    assign ex_mem_read    = mr_q;
    assign ex_mem_write   = mw_q;
    assign ex_mem_to_reg  = m2r_q;
    assign ex_branch      = br_q;
    assign ex_alu_ctrl    = alu_q;
    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;

endmodule
